// File: rtl/mavg_chan_sched.sv
// mavg_chan_sched
// ----------------------------------------------------------------------------
// One WINDOW-tap boxcar averager (sum >> log2(WINDOW)) time-shared round-robin
// among NCH sample channels. Each channel keeps its own circular write pointer,
// warm-up count, running accumulator and WINDOW-deep sample history. At most
// one sample is consumed per clock. The average appears in the output holding
// register one clock after acceptance, tagged with its channel index.
//
// Parameters:
//   WIDTH  - sample width (unsigned)
//   WINDOW - taps per channel, power of two, >= 2
//   NCH    - number of channels, >= 2
//
// Ports:
//   clk, rst    - clock, synchronous active-high reset
//   s_valid     - per-channel sample request
//   s_data      - channel i sample at [i*WIDTH +: WIDTH]
//   s_ready     - combinational one-hot grant
//   chan_clear  - per-channel window restart (wins over a same-cycle request)
//   m_valid     - output register holds a result
//   m_ready     - downstream accepts the result
//   m_data      - window average, WIDTH+log2(WINDOW) bits
//   m_chan      - channel index of m_data
//
// Optional build macro MAVG_SCHED_STATS_EN adds:
//   stall_clr   - clear the stall counter (priority over increment)
//   stall_cnt   - saturating count of cycles with a request but no free slot
//
// Handshake: a transfer occurs on a rising edge where valid && ready are both
// high. valid never depends on ready. On the output side, once m_valid rises
// m_valid/m_data/m_chan hold until m_ready is seen. On the input side s_ready
// is a combinational grant: at most one bit, and only while the output slot is
// free (empty, or being drained this cycle).
// ----------------------------------------------------------------------------
module mavg_chan_sched #(
  parameter int WIDTH  = 16,
  parameter int WINDOW = 4,
  parameter int NCH    = 4
) (
  input  logic                               clk,
  input  logic                               rst,
`ifdef MAVG_SCHED_STATS_EN
  input  logic                               stall_clr,
  output logic [15:0]                        stall_cnt,
`endif
  input  logic [NCH-1:0]                     s_valid,
  input  logic [NCH*WIDTH-1:0]               s_data,
  output logic [NCH-1:0]                     s_ready,
  input  logic [NCH-1:0]                     chan_clear,
  output logic                               m_valid,
  input  logic                               m_ready,
  output logic [WIDTH+$clog2(WINDOW)-1:0]    m_data,
  output logic [$clog2(NCH)-1:0]             m_chan
);

  localparam int CW = $clog2(NCH);
  localparam int LG = $clog2(WINDOW);
  localparam int AW = WIDTH + LG;

  // Per-channel state
  logic [LG-1:0]    ptr_r  [NCH];
  logic [LG:0]      cnt_r  [NCH];
  logic [AW-1:0]    acc_r  [NCH];
  logic [WIDTH-1:0] hist_r [NCH][WINDOW];
  logic [CW-1:0]    rr_ptr;

  // Arbitration
  logic [NCH-1:0] eligible;
  logic           slot_free;
  logic           grant_any;
  logic [CW-1:0]  grant_idx;
  logic [CW-1:0]  cand;

  always_comb begin
    eligible  = s_valid & ~chan_clear;
    slot_free = !m_valid || m_ready;
    grant_any = 1'b0;
    grant_idx = '0;
    cand      = '0;
    // Walk offsets from the far end back toward rr_ptr; the last hit written
    // is the first eligible channel in round-robin order, so no early exit.
    for (int i = NCH - 1; i >= 0; i--) begin
      cand = CW'((int'(rr_ptr) + i) % NCH);
      if (eligible[cand]) begin
        grant_any = 1'b1;
        grant_idx = cand;
      end
    end
    if (!slot_free || rst) grant_any = 1'b0;
    s_ready = '0;
    if (grant_any) s_ready[grant_idx] = 1'b1;
  end

  // Shared datapath for the granted channel
  logic [WIDTH-1:0] g_data;
  logic [WIDTH-1:0] g_old;
  logic [AW-1:0]    g_sum;
  logic             g_out;

  always_comb begin
    g_data = '0;
    for (int i = 0; i < NCH; i++) begin
      if (grant_idx == CW'(i)) g_data = s_data[i*WIDTH +: WIDTH];
    end
    g_old = hist_r[grant_idx][ptr_r[grant_idx]];
    // The accumulator always equals the sum of the history, so the subtract
    // never underflows and AW bits hold a full window of full-scale samples.
    g_sum = acc_r[grant_idx] + AW'(g_data) - AW'(g_old);
    // This sample completes (or extends) a full window
    g_out = (cnt_r[grant_idx] >= (LG+1)'(WINDOW - 1));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int c = 0; c < NCH; c++) begin
        ptr_r[c] <= '0;
        cnt_r[c] <= '0;
        acc_r[c] <= '0;
        for (int w = 0; w < WINDOW; w++) hist_r[c][w] <= '0;
      end
      rr_ptr  <= '0;
      m_valid <= 1'b0;
      m_data  <= '0;
      m_chan  <= '0;
    end else begin
      // A cleared channel is never granted in the same cycle, so these
      // writes never collide with the update below.
      for (int c = 0; c < NCH; c++) begin
        if (chan_clear[c]) begin
          ptr_r[c] <= '0;
          cnt_r[c] <= '0;
          acc_r[c] <= '0;
          for (int w = 0; w < WINDOW; w++) hist_r[c][w] <= '0;
        end
      end

      if (grant_any) begin
        acc_r[grant_idx]                    <= g_sum;
        hist_r[grant_idx][ptr_r[grant_idx]] <= g_data;
        ptr_r[grant_idx]                    <= ptr_r[grant_idx] + 1'b1;
        if (cnt_r[grant_idx] != (LG+1)'(WINDOW))
          cnt_r[grant_idx] <= cnt_r[grant_idx] + 1'b1;
        rr_ptr <= (grant_idx == CW'(NCH - 1)) ? '0 : grant_idx + 1'b1;
      end

      // A grant only happens with the slot free, so loading here never
      // overwrites an unconsumed result.
      if (grant_any && g_out) begin
        m_valid <= 1'b1;
        m_data  <= g_sum >> LG;
        m_chan  <= grant_idx;
      end else if (m_ready) begin
        m_valid <= 1'b0;
      end
    end
  end

`ifdef MAVG_SCHED_STATS_EN
  always_ff @(posedge clk) begin
    if (rst || stall_clr) begin
      stall_cnt <= '0;
    end else if (|s_valid && !slot_free && stall_cnt != 16'hFFFF) begin
      stall_cnt <= stall_cnt + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_mavg_chan_sched.sv
// Bench for mavg_chan_sched: directed scenarios plus a random mix, with a
// reference arbiter and a direct-sum window model feeding an expected queue.
module tb_mavg_chan_sched;

  localparam int WIDTH  = 16;
  localparam int WINDOW = 4;
  localparam int NCH    = 4;
  localparam int CW     = 2;
  localparam int LG     = 2;
  localparam int OW     = WIDTH + LG;

  // ---------------- clock / reset ----------------
  logic                 clk = 1'b0;
  logic                 rst;
  logic [NCH-1:0]       s_valid;
  logic [NCH*WIDTH-1:0] s_data;
  logic [NCH-1:0]       s_ready;
  logic [NCH-1:0]       chan_clear;
  logic                 m_valid;
  logic                 m_ready;
  logic [OW-1:0]        m_data;
  logic [CW-1:0]        m_chan;
`ifdef MAVG_SCHED_STATS_EN
  logic                 stall_clr;
  logic [15:0]          stall_cnt;
  int                   mstall;
`endif

  always #5 clk = ~clk;

  mavg_chan_sched #(.WIDTH(WIDTH), .WINDOW(WINDOW), .NCH(NCH)) dut (
    .clk        (clk),
    .rst        (rst),
`ifdef MAVG_SCHED_STATS_EN
    .stall_clr  (stall_clr),
    .stall_cnt  (stall_cnt),
`endif
    .s_valid    (s_valid),
    .s_data     (s_data),
    .s_ready    (s_ready),
    .chan_clear (chan_clear),
    .m_valid    (m_valid),
    .m_ready    (m_ready),
    .m_data     (m_data),
    .m_chan     (m_chan)
  );

  // ---------------- scoreboard / model ----------------
  int checks   = 0;
  int failures = 0;
  logic [CW+OW-1:0] exp_q[$];
  longint mh[NCH][WINDOW];
  int     mwp[NCH];
  int     mcnt[NCH];
  int     mrr;
  bit     mvalid;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic model_clear_chan(input int c);
    for (int w = 0; w < WINDOW; w++) mh[c][w] = 0;
    mwp[c]  = 0;
    mcnt[c] = 0;
  endtask

  // ---------------- driver tasks ----------------
  task automatic set_data(input int c, input int v);
    s_data[c*WIDTH +: WIDTH] = WIDTH'(v);
  endtask

  // Evaluate the cycle currently being driven, advance the model, then step
  // past the next rising edge.
  task automatic tick();
    int g;
    int c;
    bit sf;
    longint sum;
    logic [NCH-1:0] exp_ready;
    logic [CW+OW-1:0] e;
    #1;
    sf = !mvalid || m_ready;
    g  = -1;
    if (sf) begin
      for (int i = 0; i < NCH; i++) begin
        c = (mrr + i) % NCH;
        if (g < 0 && s_valid[c] && !chan_clear[c]) g = c;
      end
    end
    exp_ready = '0;
    if (g >= 0) exp_ready[g] = 1'b1;
    check("s_ready", s_ready, exp_ready);
    check("m_valid", m_valid, mvalid);
`ifdef MAVG_SCHED_STATS_EN
    check("stall_cnt", stall_cnt, mstall);
    if (stall_clr) mstall = 0;
    else if (|s_valid && !sf && mstall != 65535) mstall++;
`endif
    if (mvalid && m_ready) begin
      if (exp_q.size() == 0) begin
        check("unexpected_output", 1, 0);
      end else begin
        e = exp_q.pop_front();
        check("m_chan", m_chan, e[CW+OW-1:OW]);
        check("m_data", m_data, e[OW-1:0]);
      end
    end
    for (int k = 0; k < NCH; k++) if (chan_clear[k]) model_clear_chan(k);
    if (g >= 0) begin
      mh[g][mwp[g]] = longint'(s_data[g*WIDTH +: WIDTH]);
      mwp[g] = (mwp[g] + 1) % WINDOW;
      if (mcnt[g] < WINDOW) mcnt[g]++;
      mrr = (g + 1) % NCH;
      if (mcnt[g] == WINDOW) begin
        sum = 0;
        for (int w = 0; w < WINDOW; w++) sum += mh[g][w];
        exp_q.push_back({CW'(g), OW'(sum / WINDOW)});
        mvalid = 1'b1;
      end else if (m_ready) begin
        mvalid = 1'b0;
      end
    end else if (m_ready) begin
      mvalid = 1'b0;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst        = 1'b1;
    s_valid    = '1;
    chan_clear = '0;
    m_ready    = 1'b1;
    s_data     = '0;
`ifdef MAVG_SCHED_STATS_EN
    stall_clr  = 1'b0;
`endif
    @(posedge clk); #1;
    @(posedge clk); #1;
    check("rst_s_ready", s_ready, 0);
    check("rst_m_valid", m_valid, 0);
    check("rst_m_data", m_data, 0);
    check("rst_m_chan", m_chan, 0);
    rst     = 1'b0;
    s_valid = '0;
    for (int c = 0; c < NCH; c++) model_clear_chan(c);
    mrr    = 0;
    mvalid = 1'b0;
    exp_q.delete();
`ifdef MAVG_SCHED_STATS_EN
    mstall = 0;
`endif
  endtask

  task automatic drain(input string tag);
    s_valid    = '0;
    chan_clear = '0;
    m_ready    = 1'b1;
    tick();
    tick();
    check(tag, exp_q.size(), 0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int warm_vals[5];
    int ch2_vals[4];
    warm_vals = '{4, 8, 12, 16, 20};
    ch2_vals  = '{7, 11, 13, 17};

    do_reset();

    // Warm-up on ch0 alone
    for (int i = 0; i < 5; i++) begin
      s_valid = 4'b0001;
      set_data(0, warm_vals[i]);
      tick();
      if (i == 3) begin
        check("warm_avg0", m_data, 10);
        check("warm_chan0", m_chan, 0);
      end
      if (i == 4) check("warm_avg1", m_data, 14);
    end
    drain("drain_warm");

    // Round-robin with all channels valid
    do_reset();
    for (int c = 0; c < NCH; c++) set_data(c, 100 * (c + 1));
    s_valid = '1;
    for (int i = 0; i < 16; i++) tick();
    check("rr_last_chan", m_chan, 3);
    check("rr_last_data", m_data, 400);

    // Backpressure: held result must stay the scoreboard head
    m_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      check("bp_hold_data", m_data, exp_q[0][OW-1:0]);
      check("bp_hold_chan", m_chan, exp_q[0][CW+OW-1:OW]);
    end
    m_ready = 1'b1;
    for (int i = 0; i < 8; i++) tick();
    drain("drain_rr");

    // Clear collision on ch2 while ch0 keeps going
    s_valid    = 4'b0101;
    chan_clear = 4'b0100;
    set_data(2, 500);
    tick();
    chan_clear = '0;
    s_valid    = 4'b0100;
    for (int i = 0; i < 4; i++) begin
      set_data(2, ch2_vals[i]);
      tick();
    end
    check("clr_avg", m_data, 12);
    check("clr_chan", m_chan, 2);
    drain("drain_clr");

    // Full scale on ch1
    s_valid = 4'b0010;
    set_data(1, 16'hFFFF);
    for (int i = 0; i < 1100; i++) tick();
    check("full_scale", m_data, 16'hFFFF);
    drain("drain_full");

    // Random mix
    for (int i = 0; i < 400; i++) begin
      for (int c = 0; c < NCH; c++) begin
        s_valid[c]    = ($urandom_range(0, 3) != 0);
        chan_clear[c] = ($urandom_range(0, 15) == 0);
        set_data(c, int'($urandom_range(0, 65535)));
      end
      m_ready = ($urandom_range(0, 3) != 0);
      tick();
    end
    drain("drain_rand");

`ifdef MAVG_SCHED_STATS_EN
    do_reset();
    s_valid = 4'b1000;
    set_data(3, 50);
    for (int i = 0; i < 3; i++) tick();
    m_ready = 1'b0;
    tick();
    stall_clr = 1'b1;
    tick();
    stall_clr = 1'b0;
    for (int i = 0; i < 3; i++) tick();
    check("stall_three", stall_cnt, 3);
    stall_clr = 1'b1;
    tick();
    stall_clr = 1'b0;
    check("stall_cleared", stall_cnt, 0);
    for (int i = 0; i < 70000; i++) tick();
    check("stall_sat", stall_cnt, 16'hFFFF);
    drain("drain_stats");
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mavg_chan_sched.md
Name: mavg_chan_sched

Overview:
- Round-robin scheduler that time-shares one moving-average engine (WINDOW-tap boxcar, sum >> log2(WINDOW)) among NCH independent sample channels.
- Per-channel state is held internally: circular pointer, warm-up count, accumulator and WINDOW-deep history.
- One sample is processed per clock. The result is tagged with its channel index.
- Sits between multi-channel ADC/demod front ends and downstream detectors, in place of NCH separate averagers.

Parameters:
- WIDTH, 16, input sample width (unsigned).
- WINDOW, 4, taps per channel; power of 2, >= 2.
- NCH, 4, number of requesting channels; >= 2.
- CW, $clog2(NCH), width of the channel tag (derived localparam).

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous reset, active-high
- s_valid  in  NCH  per-channel sample request
- s_data  in  NCH*WIDTH  channel i occupies bits [i*WIDTH +: WIDTH]
- s_ready  out  NCH  combinational grant; sample i is accepted when s_valid[i] && s_ready[i]
- chan_clear  in  NCH  per-channel window restart
- m_valid  out  1  output holding register valid
- m_ready  in  1  downstream accept
- m_data  out  WIDTH+$clog2(WINDOW)  window average
- m_chan  out  CW  channel index of m_data

Behaviour:
- Reset: s_ready=0; m_valid=0; m_data=0; m_chan=0; rr_ptr=0. All per-channel ptr, cnt, acc and history are cleared to 0.
- Slot free: `slot_free = !m_valid || m_ready`.
- Arbitration:
  - Eligible = s_valid & ~chan_clear.
  - When slot_free, grant the first eligible channel searching upward from rr_ptr, with wrap-around. At most one s_ready bit is high.
  - When !slot_free, s_ready=0.
  - After a grant to channel g, rr_ptr <= (g+1) mod NCH. With no grant, rr_ptr holds.
- Accepted sample d on channel g, all updates in the same cycle:
  - sum = acc[g] + d - hist[g][ptr[g]], computed at ACC width WIDTH+LG (exact, no overflow).
  - acc[g] <= sum.
  - hist[g][ptr[g]] <= d.
  - ptr[g] <= ptr[g]+1, wrapping mod WINDOW.
  - cnt[g] <= cnt[g]+1, saturating at WINDOW.
- Output:
  - If pre-update cnt[g] >= WINDOW-1, the next cycle has m_valid=1, m_data=sum>>LG, m_chan=g. Latency is 1 clock from acceptance.
  - Warm-up samples (the first WINDOW-1 after reset or clear) update state but produce no output.
  - If a grant produces no output, m_valid <= 0 if it was consumed.
- Backpressure:
  - m_valid, m_data and m_chan hold stable while m_valid && !m_ready.
  - Simultaneous m_ready and a new result: the register reloads with no bubble.
  - m_valid && m_ready with no new result: m_valid <= 0.
- chan_clear[i]:
  - In one cycle, zeroes ptr, cnt, acc and history of channel i. History may be zeroed lazily, provided results are identical to a full zero.
  - Clear takes priority over a same-cycle request on that channel: s_ready[i]=0 and the sample is not consumed.
  - A result already in the output register is unaffected.
  - Other channels continue undisturbed.
- Reset mid-operation: any pending output is discarded and all channels restart warm-up.
- Fairness: with all NCH channels continuously valid and m_ready=1, each channel is granted exactly once per NCH cycles.

Optional Feature:
- Macro: MAVG_SCHED_STATS_EN.
- When defined, add output `stall_cnt` (16 bits) and input `stall_clr` (1 bit).
- stall_cnt increments each cycle in which `|s_valid && !slot_free`, saturating at 16'hFFFF.
- Reset or stall_clr sets stall_cnt to 0; stall_clr has priority over increment.
- When undefined, neither port exists and there is no counter logic.

Test Plan:
- Warm-up, single channel: reset; ch0 only, samples 4,8,12,16,20 with m_ready=1. No output for the first 3. Outputs m_data=10 (40/4) then 14 (56/4), both m_chan=0, each 1 cycle after acceptance.
- Round-robin: all 4 channels valid every cycle with constant data 100,200,300,400. Grants are 0,1,2,3,0,... After warm-up, m_chan cycles 0..3 with m_data 100,200,300,400. Each channel gets exactly 1 grant per 4 cycles.
- Backpressure: m_valid=1 with m_ready=0 for 5 cycles. s_ready=0 for all channels, m_data/m_chan stable, no history change. On release, the same channel order resumes from rr_ptr.
- Clear collision: ch2 warmed up; assert chan_clear[2] together with s_valid[2] and data 500. s_ready[2]=0. The next 3 accepted ch2 samples produce no output, and the 4th gives an exact average of only post-clear samples.
- Full scale: ch1 receives 16'hFFFF continuously. m_data=16'hFFFF, with no accumulator overflow or wrap across more than 1000 samples.
- Stats (MAVG_SCHED_STATS_EN): 3 stall cycles gives stall_cnt=3. Pulse stall_clr gives 0. Force 70000 stall cycles and stall_cnt saturates at 16'hFFFF.
